instr_reg_sched: RTL and testbench
==================================

INSTR_REG_SCHED -- requirements
Module: instr_reg_sched

Interface
REQ-001 Parameter: DEPTH, 32, number of instruction-register entries; pointer width is 5.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  one-cycle request to discard all queued entries.
REQ-005 a_valid / a_ready  input / output  1 / 1  requester A handshake.
REQ-006 a_instr  input  instruction_t  requester A payload (opc, op_a, op_b).
REQ-007 b_valid / b_ready / b_instr  input / output / input  1 / 1 / instruction_t  requester B, same semantics as A.
REQ-008 load_en  output  1  write enable to the instruction register.
REQ-009 write_pointer  output  5  write address to the instruction register.
REQ-010 opcode, operand_a, operand_b  output  opcode_t, operand_t, operand_t  write data to the instruction register.
REQ-011 read_pointer  output  5  read address to the instruction register.
REQ-012 instruction_word  input  instruction_t  combinational read data from the instruction register.
REQ-013 rd_valid / rd_ready  output / input  1 / 1  consumer pop handshake.
REQ-014 rd_instr  output  instruction_t  head entry; equals instruction_word.
REQ-015 count  output  6  committed entries (0..32).

Function
REQ-016 Requester X is accepted on a rising edge where X_valid and X_ready are both high.
REQ-017 A and B are never both ready in the same cycle. A two-input round-robin grant chooses between them. The grant toggles priority to the non-winner after each acceptance. Priority after reset is A.
REQ-018 A grant needs state RUN and occupancy < 32. Occupancy is a registered value only; a same-cycle pop does not free a slot.
REQ-019 An accepted payload is registered into the opcode/operand outputs. write_pointer receives wr_ptr and load_en is 1 for exactly the next cycle. The instruction register therefore writes one edge after acceptance.
REQ-020 wr_ptr increments on each acceptance and wraps from 31 to 0. rd_ptr increments on each pop and also wraps from 31 to 0.
REQ-021 Occupancy +1 on acceptance and -1 on pop. A simultaneous acceptance and pop leaves occupancy unchanged.
REQ-022 count (committed) +1 on the edge where load_en=1, and -1 on pop. Simultaneous events cancel.
REQ-023 rd_valid equals (count != 0) and state == RUN.
REQ-024 read_pointer equals rd_ptr. rd_instr equals instruction_word, combinational.
REQ-025 A pop occurs when rd_valid and rd_ready are both high. rd_valid never depends on rd_ready.
REQ-026 FSM states are RUN and FLUSH.
REQ-027 RUN to FLUSH happens on flush=1. In FLUSH, a_ready, b_ready and rd_valid are 0.
REQ-028 A write already in the pipeline still completes in the first FLUSH cycle (load_en=1).
REQ-029 FLUSH to RUN happens after exactly one cycle. wr_ptr, rd_ptr, occupancy, count and the grant priority clear to reset values on that edge.
REQ-030 flush=1 while in FLUSH is ignored.
REQ-031 An acceptance or pop in the same cycle as flush=1 still completes, and is then discarded by the flush.
REQ-032 No overflow or underflow is possible: occupancy is never above 32 and count is never below 0.

Reset
REQ-033 reset_n=0 drives all state and outputs immediately: state=RUN, wr_ptr=0, rd_ptr=0, occupancy=0, count=0, load_en=0, write_pointer=0, opcode=0, operand_a=0, operand_b=0, priority=A.
REQ-034 During reset, read_pointer=0, a_ready=0, b_ready=0 and rd_valid=0.
REQ-035 Reset asserted mid-transfer drops the pending write; load_en is never 1 during reset.
REQ-036 After reset_n rises, a_ready may assert in the first cycle.

Structure
REQ-037 instr_register_pkg holds opcode_t, operand_t and instruction_t (existing), plus the new IR_DEPTH=32, IR_PTR_W=5 and sched_state_t {RUN, FLUSH}.
REQ-038 Round-robin grant logic is a separate sub-module, rr_arbiter2, instantiated once.
REQ-039 The block connects to instr_register without glue logic.

Verification
REQ-040 Reset, then A pushes {ADD, 5, 3}. Required: load_en=1 at write_pointer=0 one cycle later; count=1 one cycle after that; rd_instr={ADD, 5, 3}.
REQ-041 A and B valid continuously for 6 cycles. Required: acceptance order A, B, A, B, A, B; write_pointer 0..5.
REQ-042 A pushes 32 entries with no pops. Required: a_ready=0 at occupancy 32; the 33rd request is held until a pop, then it is accepted the cycle after the pop.
REQ-043 Push 40 with pops interleaved. Required: pointers wrap 31 to 0; popped order equals pushed order; final count=0.
REQ-044 Pulse flush with 3 entries queued and one write in flight. Required: load_en completes; after 2 cycles count=0, rd_valid=0, read_pointer=0, write_pointer next=0.
REQ-045 Assert reset_n=0 asynchronously mid-push with count=7. Required: outputs reach reset values without waiting for a clock edge; no load_en pulse follows.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its write/read scheduler.
package instr_register_pkg;

  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  localparam int IR_DEPTH = 32;
  localparam int IR_PTR_W = 5;

  typedef enum logic {RUN, FLUSH} sched_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant; priority passes to the loser after every acceptance.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic clear_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic prio_b_q;
  logic pick_a;

  // With nobody requesting, the grant rests on the priority holder.
  always_comb begin
    if (prio_b_q) pick_a = req_a_i & ~req_b_i;
    else          pick_a = ~(req_b_i & ~req_a_i);
    gnt_a_o = en_i & pick_a;
    gnt_b_o = en_i & ~pick_a;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  prio_b_q <= 1'b0;
    else if (clear_i)              prio_b_q <= 1'b0;
    else if (gnt_a_o && req_a_i)   prio_b_q <= 1'b1;
    else if (gnt_b_o && req_b_i)   prio_b_q <= 1'b0;
  end

endmodule

// File: rtl/instr_reg_sched.sv
// Write/read scheduler for the instruction register: arbitrates two writers,
// pipelines accepted writes by one cycle and tracks occupancy and committed count.
//   state | meaning
//   RUN   | normal operation, accepts writes and pops
//   FLUSH | one-cycle discard; in-flight write finishes, all counters clear on exit
module instr_reg_sched
  import instr_register_pkg::*;
#(
  parameter int DEPTH = IR_DEPTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                a_valid,
  output logic                a_ready,
  input  instruction_t        a_instr,
  input  logic                b_valid,
  output logic                b_ready,
  input  instruction_t        b_instr,
  output logic                load_en,
  output logic [IR_PTR_W-1:0] write_pointer,
  output opcode_t             opcode,
  output operand_t            operand_a,
  output operand_t            operand_b,
  output logic [IR_PTR_W-1:0] read_pointer,
  input  instruction_t        instruction_word,
  output logic                rd_valid,
  input  logic                rd_ready,
  output instruction_t        rd_instr,
  output logic [IR_PTR_W:0]   count
);

  localparam logic [IR_PTR_W-1:0] PTR_LAST = IR_PTR_W'(DEPTH - 1);
  localparam logic [IR_PTR_W:0]   CNT_FULL = (IR_PTR_W + 1)'(DEPTH);

  sched_state_t        state_q, state_d;
  logic                run, clear;
  logic [IR_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IR_PTR_W-1:0] wp_q, wp_d;
  logic [IR_PTR_W:0]   occ_q, occ_d, cnt_q, cnt_d;
  logic                load_q, load_d;
  instruction_t        instr_q, instr_d;
  logic                arb_en, accept_a, accept_b, accept, pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    run   = (state_q == RUN);
    clear = (state_q == FLUSH);
  end

  // reset_n gates the handshakes so nothing is offered while reset is held.
  assign arb_en = reset_n & run & (occ_q < CNT_FULL);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (arb_en),
    .clear_i (clear),
    .req_a_i (a_valid),
    .req_b_i (b_valid),
    .gnt_a_o (a_ready),
    .gnt_b_o (b_ready)
  );

  assign accept_a = a_valid & a_ready;
  assign accept_b = b_valid & b_ready;
  assign accept   = accept_a | accept_b;
  assign rd_valid = reset_n & run & (cnt_q != '0);
  assign pop      = rd_valid & rd_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    load_d   = accept;
    wp_d     = wp_q;
    instr_d  = instr_q;
    if (accept) begin
      wp_d     = wr_ptr_q;
      instr_d  = accept_b ? b_instr : a_instr;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    case ({load_q, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Exiting FLUSH wipes the queue, including a write that just landed.
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      load_q   <= 1'b0;
      wp_q     <= '0;
      instr_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      wp_q     <= wp_d;
      instr_q  <= instr_d;
    end
  end

  assign load_en       = load_q;
  assign write_pointer = wp_q;
  assign opcode        = instr_q.opc;
  assign operand_a     = instr_q.op_a;
  assign operand_b     = instr_q.op_b;
  assign read_pointer  = rd_ptr_q;
  assign rd_instr      = instruction_word;
  assign count         = cnt_q;

endmodule

// File: tb/tb_instr_reg_sched.sv
// Directed bench for instr_reg_sched with a behavioural instruction register attached.
module tb_instr_reg_sched;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n, flush, a_valid, b_valid, rd_ready;
  logic         a_ready, b_ready, load_en, rd_valid;
  instruction_t a_instr, b_instr, instruction_word, rd_instr;
  logic [4:0]   write_pointer, read_pointer;
  opcode_t      opcode;
  operand_t     operand_a, operand_b;
  logic [5:0]   count;

  int checks = 0;
  int failures = 0;

  instruction_t ir_mem [32];

  always #5 clk = ~clk;

  always @(posedge clk) if (load_en) ir_mem[write_pointer] <= {opcode, operand_a, operand_b};
  assign instruction_word = ir_mem[read_pointer];

  instr_reg_sched dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .a_valid(a_valid), .a_ready(a_ready), .a_instr(a_instr),
    .b_valid(b_valid), .b_ready(b_ready), .b_instr(b_instr),
    .load_en(load_en), .write_pointer(write_pointer), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b), .read_pointer(read_pointer),
    .instruction_word(instruction_word), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_instr(rd_instr), .count(count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic instruction_t mk(input opcode_t o, input int a, input int b);
    return {o, 32'(a), 32'(b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; a_valid = 0; b_valid = 0; rd_ready = 0;
    a_instr = '0; b_instr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    #1;
    reset_n = 1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed, popped, cyc;
    reset_n = 0;
    idle_inputs();
    #3;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_count", count, 0);
    check("rst_rp", read_pointer, 0);
    check("rst_wp", write_pointer, 0);
    tick();
    check("rst_load_en", load_en, 0);
    reset_n = 1;
    #1;
    check("post_rst_a_ready", a_ready, 1);
    check("post_rst_b_ready", b_ready, 0);

    // single push then pop
    a_valid = 1; a_instr = mk(ADD, 5, 3);
    #1;
    check("p1_a_ready", a_ready, 1);
    tick();
    a_valid = 0;
    #1;
    check("p1_load_en", load_en, 1);
    check("p1_wp", write_pointer, 0);
    check("p1_opcode", opcode, ADD);
    check("p1_opa", operand_a, 5);
    check("p1_opb", operand_b, 3);
    check("p1_count_pre", count, 0);
    tick();
    check("p1_count", count, 1);
    check("p1_rd_valid", rd_valid, 1);
    check("p1_rd_instr", rd_instr, mk(ADD, 5, 3));
    rd_ready = 1;
    tick();
    rd_ready = 0;
    #1;
    check("p1_count_pop", count, 0);
    check("p1_rp_pop", read_pointer, 1);
    check("p1_rd_valid_pop", rd_valid, 0);

    // round-robin with both requesters busy
    do_reset();
    a_valid = 1; b_valid = 1;
    for (int i = 0; i < 6; i++) begin
      a_instr = mk(PASSA, 100 + i, 0);
      b_instr = mk(PASSB, 200 + i, 0);
      #1;
      check("rr_grant", {a_ready, b_ready}, (i % 2) ? 2'b01 : 2'b10);
      tick();
      check("rr_load_en", load_en, 1);
      check("rr_wp", write_pointer, i);
      check("rr_opa", operand_a, (i % 2) ? 200 + i : 100 + i);
    end
    a_valid = 0; b_valid = 0;

    // fill to 32, 33rd request waits for a pop
    do_reset();
    a_valid = 1;
    for (int i = 0; i < 32; i++) begin
      a_instr = mk(ADD, i, i);
      #1;
      check("full_fill_ready", a_ready, 1);
      tick();
    end
    a_instr = mk(SUB, 99, 1);
    #1;
    check("full_ready_at32", a_ready, 0);
    tick();
    check("full_count32", count, 32);
    check("full_head", rd_instr, mk(ADD, 0, 0));
    check("full_ready_held", a_ready, 0);
    rd_ready = 1;
    #1;
    check("full_ready_same_pop", a_ready, 0);
    tick();
    rd_ready = 0;
    #1;
    check("full_count31", count, 31);
    check("full_rp1", read_pointer, 1);
    check("full_ready_after_pop", a_ready, 1);
    tick();
    a_valid = 0;
    #1;
    check("full_33_load_en", load_en, 1);
    check("full_33_wp_wrap", write_pointer, 0);
    check("full_33_opcode", opcode, SUB);
    tick();
    check("full_count_back32", count, 32);

    // 40 pushes with interleaved pops, pointers wrap
    do_reset();
    pushed = 0; popped = 0; cyc = 0;
    while (popped < 40 && cyc < 300) begin
      a_valid  = (pushed < 40);
      a_instr  = mk(MULT, pushed, 7);
      rd_ready = (cyc % 3 != 2);
      #1;
      if (rd_valid && rd_ready) begin
        check("wrap_order", rd_instr.op_a, popped);
        check("wrap_rp", read_pointer, popped % 32);
        popped++;
      end
      if (a_valid && a_ready) pushed++;
      tick();
      cyc++;
    end
    a_valid = 0; rd_ready = 0;
    #1;
    check("wrap_done", cyc < 300, 1);
    check("wrap_pushed", pushed, 40);
    check("wrap_final_count", count, 0);
    check("wrap_final_rp", read_pointer, 8);
    check("wrap_final_rd_valid", rd_valid, 0);

    // flush with 3 committed and one write in flight
    do_reset();
    a_valid = 1;
    for (int i = 0; i < 3; i++) begin
      a_instr = mk(DIV, i, 0);
      tick();
    end
    a_instr = mk(DIV, 3, 0);
    flush = 1;
    #1;
    check("fl_accept_with_flush", a_ready, 1);
    tick();
    check("fl_load_en", load_en, 1);
    check("fl_wp", write_pointer, 3);
    check("fl_count", count, 3);
    check("fl_a_ready", a_ready, 0);
    check("fl_b_ready", b_ready, 0);
    check("fl_rd_valid", rd_valid, 0);
    tick();
    flush = 0;
    b_valid = 1;
    a_instr = mk(PASSA, 1, 1);
    b_instr = mk(MOD, 9, 9);
    #1;
    check("fl_count_clr", count, 0);
    check("fl_rd_valid_clr", rd_valid, 0);
    check("fl_rp_clr", read_pointer, 0);
    check("fl_load_idle", load_en, 0);
    check("fl_prio_a", {a_ready, b_ready}, 2'b10);
    tick();
    a_valid = 0; b_valid = 0;
    #1;
    check("fl_next_load", load_en, 1);
    check("fl_next_wp", write_pointer, 0);
    check("fl_next_opa", operand_a, 1);
    tick();
    check("fl_next_count", count, 1);

    // async reset in the middle of a push stream
    do_reset();
    a_valid = 1;
    for (int i = 0; i < 8; i++) begin
      a_instr = mk(ADD, i + 1, i);
      tick();
    end
    check("ar_count7", count, 7);
    check("ar_inflight", load_en, 1);
    #2;
    reset_n = 0;
    #1;
    check("ar_load_en", load_en, 0);
    check("ar_count", count, 0);
    check("ar_wp", write_pointer, 0);
    check("ar_opcode", opcode, ZERO);
    check("ar_opa", operand_a, 0);
    check("ar_opb", operand_b, 0);
    check("ar_a_ready", a_ready, 0);
    check("ar_b_ready", b_ready, 0);
    check("ar_rd_valid", rd_valid, 0);
    check("ar_rp", read_pointer, 0);
    tick();
    check("ar_load_held", load_en, 0);
    a_valid = 0;
    reset_n = 1;
    tick();
    check("ar_no_pulse", load_en, 0);
    check("ar_count_after", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
